// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_WIDTH / CLA_GROUP / CLA_STAGES : default operand width, bits per
//                                        lookahead group, pipeline stages
//   cla_ctrl_t  : per-stage register record control part (valid bit and the
//                 group carry handed to the next stage). The data part of the
//                 record (partial result, operand remainder) depends on WIDTH,
//                 so it is declared next to the control record in the top.
//   cla_flags_t : ovf/zero storage, present only with PIPELINED_CLA_FLAGS_EN.
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_WIDTH  = 16;
    localparam int CLA_GROUP  = 4;
    localparam int CLA_STAGES = 2;

    typedef struct packed {
        logic valid;
        logic carry;
    } cla_ctrl_t;

`ifdef PIPELINED_CLA_FLAGS_EN
    typedef struct packed {
        logic ovf;
        logic zero;
    } cla_flags_t;
`endif

endpackage

// File: rtl/pipelined_cla_adder_group.sv
// -----------------------------------------------------------------------------
// cla_group
// One GROUP-bit carry-lookahead slice. Every internal carry is formed directly
// from the bit generate/propagate terms and c_in, so no ripple path exists
// inside the group.
// Ports:
//   a, b  : GROUP-bit operand slices
//   c_in  : carry into bit 0 of the slice
//   sum   : GROUP-bit sum slice
//   p, g  : group propagate / group generate (g is independent of c_in)
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] sum,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] bit_p;
    logic [GROUP-1:0] bit_g;
    logic [GROUP-1:0] carry;
    logic             gen;
    logic             prop;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Carry into bit i is the OR of every lower generate whose path up to i
    // fully propagates, plus c_in when all lower bits propagate. The same
    // expansion over the whole slice (without c_in) gives the group generate.
    always_comb begin
        carry = '0;
        gen   = 1'b0;
        prop  = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            gen  = 1'b0;
            prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                gen  = gen | (bit_g[j] & prop);
                prop = prop & bit_p[j];
            end
            carry[i] = gen | (c_in & prop);
        end
        gen  = 1'b0;
        prop = 1'b1;
        for (int j = GROUP - 1; j >= 0; j--) begin
            gen  = gen | (bit_g[j] & prop);
            prop = prop & bit_p[j];
        end
        g = gen;
    end

    assign p   = &bit_p;
    assign sum = bit_p ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// Elastic pipelined carry-lookahead adder/subtractor.
// Slot 0 captures the operands (B already inverted for subtraction, carry-in
// forced to 1). Stage s then resolves its share of the lookahead groups from
// slot s and writes slot s+1; slot STAGES drives the outputs. A result thus
// appears STAGES clock edges after the edge that accepted its operands, and
// the pipeline holds STAGES+1 operations when the consumer stalls.
// Optional feature macro: PIPELINED_CLA_FLAGS_EN (ovf/zero flag logic; when
// undefined both flags are tied 0 and no flag storage exists).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   A, B, cin, sub       : operands, carry-in (ignored when sub=1), subtract
//   out_valid / out_ready: result handshake
//   R, cout              : result modulo 2^WIDTH, carry out (sub: 1 = no borrow)
//   ovf, zero            : signed overflow, R == 0
// -----------------------------------------------------------------------------
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = CLA_WIDTH,
    parameter int GROUP  = CLA_GROUP,
    parameter int STAGES = CLA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGROUPS = WIDTH / GROUP;
    localparam int GPS     = (STAGES > 0) ? NGROUPS / STAGES : 1;
    localparam int SLICE   = GPS * GROUP;

    if (STAGES < 1 || GROUP < 1) begin : g_bad_params
        $error("pipelined_cla_adder: STAGES and GROUP must be at least 1");
    end else if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_split
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP*STAGES");
    end

    // Per-slot register record: control in ctrl, data in opa/opb/res.
    cla_ctrl_t                     ctrl [0:STAGES];
    logic [WIDTH-1:0]              opa  [0:STAGES-1];
    logic [WIDTH-1:0]              opb  [0:STAGES-1];
    logic [WIDTH-1:0]              res  [1:STAGES];
    logic [STAGES-1:0][WIDTH-1:0]  next_res;
    logic [STAGES-1:0]             next_carry;
    logic [STAGES:0]               free;

    // A slot can take new contents when it is empty or its occupant moves on
    // this cycle; the chain runs from the output back to the input so a full
    // pipeline can accept and drain in the same cycle.
    assign free[STAGES] = ~ctrl[STAGES].valid | out_ready;
    for (genvar k = 0; k < STAGES; k++) begin : g_free
        assign free[k] = ~ctrl[k].valid | free[k+1];
    end

    assign in_ready = rst_n & free[0];

    // Stage s resolves groups s*GPS .. s*GPS+GPS-1, starting from the group
    // carry stored in slot s and adding its sum slice above the bits already
    // produced by earlier stages (bits above the slice are still zero).
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [GPS:0]       c;
        logic [SLICE-1:0]   slice_sum;
        logic [WIDTH-1:0]   base;

        assign c[0] = ctrl[s].carry;

        for (genvar gi = 0; gi < GPS; gi++) begin : g_grp
            logic grp_p;
            logic grp_g;

            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .a    (opa[s][(s*GPS+gi)*GROUP +: GROUP]),
                .b    (opb[s][(s*GPS+gi)*GROUP +: GROUP]),
                .c_in (c[gi]),
                .sum  (slice_sum[gi*GROUP +: GROUP]),
                .p    (grp_p),
                .g    (grp_g)
            );

            assign c[gi+1] = grp_g | (grp_p & c[gi]);
        end

        if (s == 0) begin : g_first
            assign base = '0;
        end else begin : g_rest
            assign base = res[s];
        end

        assign next_res[s]   = base | (WIDTH'(slice_sum) << (s * SLICE));
        assign next_carry[s] = c[GPS];
    end

    // Slot registers. Data only loads alongside a valid entry, so outputs
    // keep their last values while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                ctrl[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                opa[k] <= '0;
                opb[k] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                res[k] <= '0;
            end
        end else begin
            if (free[0]) begin
                ctrl[0].valid <= in_valid;
                if (in_valid) begin
                    ctrl[0].carry <= sub | cin;
                    opa[0]        <= A;
                    opb[0]        <= sub ? ~B : B;
                end
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (free[k]) begin
                    ctrl[k].valid <= ctrl[k-1].valid;
                    if (ctrl[k-1].valid) begin
                        ctrl[k].carry <= next_carry[k-1];
                        res[k]        <= next_res[k-1];
                    end
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (free[k] && ctrl[k-1].valid) begin
                    opa[k] <= opa[k-1];
                    opb[k] <= opb[k-1];
                end
            end
        end
    end

    assign out_valid = ctrl[STAGES].valid;
    assign R         = res[STAGES];
    assign cout      = ctrl[STAGES].carry;

`ifdef PIPELINED_CLA_FLAGS_EN
    cla_flags_t flags_d;
    cla_flags_t flags_q;
    logic       msb_carry;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    always_comb begin
        msb_carry    = next_res[STAGES-1][WIDTH-1] ^ opa[STAGES-1][WIDTH-1]
                     ^ opb[STAGES-1][WIDTH-1];
        flags_d.ovf  = msb_carry ^ next_carry[STAGES-1];
        flags_d.zero = ~|next_res[STAGES-1];
    end

    // Flags travel with the result into the output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (free[STAGES] && ctrl[STAGES-1].valid) begin
            flags_q <= flags_d;
        end
    end

    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
// Self-checking bench for pipelined_cla_adder. Expected results come from a
// plain-arithmetic model queued at each accepted transfer; a compare process
// checks every valid output cycle. Flags are expected only when
// PIPELINED_CLA_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    localparam int WIDTH  = 16;
    localparam int GROUP  = 4;
    localparam int STAGES = 2;
`ifdef PIPELINED_CLA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             cout;
    logic             ovf;
    logic             zero;

    pipelined_cla_adder #(
        .WIDTH  (WIDTH),
        .GROUP  (GROUP),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               accept_edge;
    } exp_t;

    exp_t exp_q[$];
    bit   front_seen;
    bit   check_latency;
    int   edge_count;
    int   drained;
    int   checks;
    int   errors;

    logic [WIDTH-1:0] all_ones;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_count++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain modular arithmetic for R/cout, signed range test for ovf.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input logic s);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic             cc;
        logic [WIDTH:0]   total;
        longint           ssum;
        longint           smax;
        longint           smin;
        bb      = s ? ~b : b;
        cc      = s ? 1'b1 : c;
        total   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
        ssum    = longint'($signed(a)) + longint'($signed(bb)) + longint'(cc);
        smax    = (longint'(1) << (WIDTH - 1)) - 1;
        smin    = -(longint'(1) << (WIDTH - 1));
        e.r     = total[WIDTH-1:0];
        e.cout  = total[WIDTH];
        e.ovf   = FLAGS && (ssum > smax || ssum < smin);
        e.zero  = FLAGS && (e.r == '0);
        e.accept_edge = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Compare process: every negedge with out_valid high is checked against
    // the oldest outstanding model result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            front_seen = 1'b0;
            checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: R=%0h with nothing outstanding", R);
                end else begin
                    e = exp_q[0];
                    checkOutput("result_R", {{(64-WIDTH){1'b0}}, R}, {{(64-WIDTH){1'b0}}, e.r});
                    checkOutput("result_cout", {63'd0, cout}, {63'd0, e.cout});
                    checkOutput("result_ovf", {63'd0, ovf}, {63'd0, e.ovf});
                    checkOutput("result_zero", {63'd0, zero}, {63'd0, e.zero});
                    if (check_latency && !front_seen) begin
                        checkOutput("latency", 64'(edge_count - e.accept_edge), 64'(STAGES));
                    end
                    front_seen = 1'b1;
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                        drained++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(A, B, cin, sub);
                e.accept_edge = edge_count + 1;
                exp_q.push_back(e);
            end
        end
    end

    // Presents one operation and holds it until accepted; returns how many
    // cycles in_ready was low. Called and returns at posedge+2.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s, output int waited);
        bit got;
        A = a; B = b; cin = c; sub = s;
        in_valid = 1'b1;
        waited = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready never rose, waited %0d", waited);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
        if (!done) $display("[TB] drain wait expired");
        @(posedge clk);
        #2;
    endtask

    task automatic runDirected(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic c, input logic s,
                               input logic [WIDTH-1:0] exp_r, input logic exp_cout,
                               input logic exp_ovf, input logic exp_zero);
        exp_t e;
        int   waited;
        bit   seen;
        e = model(a, b, c, s);
        checkOutput({name, "_model_R"}, {{(64-WIDTH){1'b0}}, e.r}, {{(64-WIDTH){1'b0}}, exp_r});
        checkOutput({name, "_model_cout"}, {63'd0, e.cout}, {63'd0, exp_cout});
        checkOutput({name, "_model_ovf"}, {63'd0, e.ovf}, {63'd0, exp_ovf});
        applyStimulus(a, b, c, s, waited);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_out_valid"}, {63'd0, seen}, 64'd1);
        checkOutput({name, "_R"}, {{(64-WIDTH){1'b0}}, R}, {{(64-WIDTH){1'b0}}, exp_r});
        checkOutput({name, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
        checkOutput({name, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
        checkOutput({name, "_zero"}, {63'd0, zero}, {63'd0, exp_zero});
        waitDrain();
    endtask

    initial begin
        int               waited;
        int               accepts;
        int               base_drained;
        logic [WIDTH-1:0] held_r;

        checks = 0; errors = 0; edge_count = 0; drained = 0;
        front_seen = 1'b0; check_latency = 1'b1;
        all_ones = '1;
        in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        rst_n = 1'b1;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("reset_R", {{(64-WIDTH){1'b0}}, R}, 64'd0);
        checkOutput("reset_cout", {63'd0, cout}, 64'd0);
        checkOutput("reset_flags", {62'd0, ovf, zero}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #2;

        // Directed corner cases
        runDirected("wrap", all_ones, WIDTH'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0, FLAGS);
        runDirected("pos_ovf", all_ones >> 1, WIDTH'(1), 1'b0, 1'b0, ~(all_ones >> 1),
                    1'b0, FLAGS, 1'b0);
        runDirected("sub_borrow", WIDTH'(5), WIDTH'(7), 1'b1, 1'b1, all_ones - WIDTH'(1),
                    1'b0, 1'b0, 1'b0);
        runDirected("sub_equal", WIDTH'(1234), WIDTH'(1234), 1'b0, 1'b1, '0, 1'b1, 1'b0, FLAGS);
        runDirected("carry_in", all_ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, FLAGS);

        // Back-to-back stream with out_ready held high
        base_drained = drained;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), waited);
            checkOutput("stream_in_ready", 64'(waited), 64'd0);
        end
        waitDrain();
        checkOutput("stream_count", 64'(drained - base_drained), 64'd8);
        check_latency = 1'b0;

        // Fill with the consumer stalled
        out_ready = 1'b0;
        base_drained = drained;
        accepts = 0;
        in_valid = 1'b1;
        for (int i = 0; i < STAGES + 4; i++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            if (!in_ready) break;
            accepts++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        checkOutput("stall_accepts", 64'(accepts), 64'(STAGES + 1));
        @(negedge clk);
        held_r = R;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("stall_R_frozen", {{(64-WIDTH){1'b0}}, R}, {{(64-WIDTH){1'b0}}, held_r});
        end
        @(posedge clk);
        #2;
        // Full pipeline: draining and accepting in the same cycle
        A = WIDTH'($urandom); B = WIDTH'($urandom); cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("full_accept_drain", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        waitDrain();
        checkOutput("stall_drained", 64'(drained - base_drained), 64'(STAGES + 2));

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            A = WIDTH'($urandom); B = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        // Reset with two operations in flight
        applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, waited);
        applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0, waited);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_R", {{(64-WIDTH){1'b0}}, R}, 64'd0);
        checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("midreset_release_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no_stale_result", {63'd0, out_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter GROUP, default 4, meaning bits per carry-lookahead group.
REQ-003 SHALL have parameter STAGES, default 2, meaning pipeline register stages, i.e. latency in cycles (legal 1..WIDTH/GROUP).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, operands presented.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have ports A and B, input, WIDTH each, operands.
REQ-009 SHALL have port cin, input, 1, carry-in (ignored when sub=1).
REQ-010 SHALL have port sub, input, 1, 1 = compute A-B.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port R, output, WIDTH, sum/difference modulo 2^WIDTH.
REQ-014 SHALL have port cout, output, 1, carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 SHALL have ports ovf and zero, output, 1 each, signed overflow and R==0.

Function
REQ-016 Effective operation SHALL be A + B + cin when sub=0, and A + ~B + 1 when sub=1.
REQ-017 Carries SHALL use per-group generate/propagate lookahead; the carry chain SHALL be split evenly across STAGES, with one group-carry register boundary per stage.
REQ-018 A transfer SHALL occur on in_valid & in_ready; result SHALL appear with out_valid exactly STAGES cycles later if out_ready was held high.
REQ-019 Each stage SHALL hold a valid bit; a stage SHALL advance when the next stage is empty or advancing (elastic, no bubbles required).
REQ-020 in_ready SHALL be high when stage 0 is empty or advancing; sustained throughput SHALL be one operation per cycle.
REQ-021 out_valid high with out_ready low SHALL freeze R, cout, ovf, zero and out_valid; no data SHALL be lost or duplicated.
REQ-022 Simultaneous accept at input and drain at output on a full pipeline SHALL be allowed in the same cycle.
REQ-023 ovf SHALL be (carry into MSB) XOR cout; zero SHALL be asserted when all bits of R are 0.
REQ-024 When out_valid is low, R, cout, ovf, zero SHALL hold their last values (don't-care for checking).

Reset
REQ-025 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, R=0, cout=0, ovf=0, zero=0.
REQ-026 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-027 Operations in flight at reset assertion SHALL be discarded; none SHALL emerge after release.

Configuration
REQ-028 Macro PIPELINED_CLA_FLAGS_EN SHALL gate flag logic.
REQ-029 With PIPELINED_CLA_FLAGS_EN defined, ovf and zero SHALL behave per REQ-023 and be carried through the pipeline.
REQ-030 Without it, ovf and zero SHALL be tied 0 and their pipeline storage SHALL not exist; R, cout and timing SHALL be unchanged.

Structure
REQ-031 Package cla_pkg SHALL hold default WIDTH/GROUP/STAGES constants and a typedef for the per-stage register record (valid, partial R, group carry, operand remainder, flags).
REQ-032 Sub-module cla_group SHALL implement one GROUP-bit lookahead slice: inputs a, b, c_in; outputs sum, group P, group G.
REQ-033 Elaboration SHALL fail if WIDTH mod (GROUP*STAGES) != 0.

Verification
REQ-034 Defaults, A=16'hFFFF, B=16'h0001, cin=0, sub=0 -> 2 cycles later R=16'h0000, cout=1, zero=1, ovf=0.
REQ-035 A=16'h7FFF, B=16'h0001, sub=0 -> R=16'h8000, ovf=1, cout=0; A=16'h0005, B=16'h0007, sub=1 -> R=16'hFFFE, cout=0.
REQ-036 Stream 8 back-to-back random operations with out_ready=1 -> in_ready never low, 8 results in order, each STAGES cycles after accept, matching the reference sum.
REQ-037 Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready falls after STAGES+1 accepts, outputs stable; release -> all results drain in order, none lost.
REQ-038 Assert rst_n low with 2 operations in flight -> out_valid=0 and R=0 within the same cycle; after release no stale result appears.
REQ-039 Repeat REQ-034..REQ-036 with WIDTH=32, GROUP=8, STAGES=4 and with PIPELINED_CLA_FLAGS_EN undefined -> R/cout identical, ovf=zero=0.
